// File: rtl/mealy_seq_detector.sv
// Run-time programmable Mealy serial sequence detector with selectable overlap.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module mealy_seq_detector #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             din,
  output logic             match,
  output logic             match_q,
  output logic [LEN_W-1:0] fill,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  // The oldest history bit would only ever be shifted out, so it is not stored.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;

  logic [LEN_W-1:0] len_cap;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] len_mask;
  logic             hit;

  assign cand = {hist_q, din};
  assign fill = fill_q;

  always_comb begin
    if (len_in == '0) begin
      len_cap = ONE_L;
    end else if (len_in > PAT_W_L) begin
      len_cap = PAT_W_L;
    end else begin
      len_cap = len_in;
    end
  end

  always_comb begin
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Enough history plus the current bit, and the low L bits agree with the pattern.
  assign hit = (fill_q >= (len_q - ONE_L)) && (((cand ^ pat_q) & len_mask) == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q   <= '0;
      len_q   <= ONE_L;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match;
    end
  end

  // Next-state logic; load takes priority and discards din.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (load) begin
      pat_d  = pat_in;
      len_d  = len_cap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = cand[PAT_W-2:0];
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + ONE_L;
      end
    end
  end

  // Mealy output: registers plus current inputs only, no clock term.
  always_comb begin
    match = in_valid && !load && hit;
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed scoreboard bench for mealy_seq_detector; expected counter follows SEQ_DET_CNT_EN.
module tb_mealy_seq_detector;

  localparam int PAT_W   = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] len_in;
  logic             overlap;
  logic             in_valid;
  logic             din;
  logic             match;
  logic             match_q;
  logic [LEN_W-1:0] fill;
  logic [CNT_W-1:0] match_cnt;

  int   tests   = 0;
  int   fails   = 0;
  int   step_no = 0;
  int   exp_cnt = 0;
  logic last_m  = 1'b0;
  logic exp_q[$];

  mealy_seq_detector #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .pat_in   (pat_in),
    .len_in   (len_in),
    .overlap  (overlap),
    .in_valid (in_valid),
    .din      (din),
    .match    (match),
    .match_q  (match_q),
    .fill     (fill),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of stimulus expected end before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: comb match at negedge, match_q/counter after the edge.
  task automatic step(input logic ld, input logic v, input logic d, input logic exp_m);
    logic exp_now;
    load     = ld;
    in_valid = v;
    din      = d;
    exp_q.push_back(exp_m);
    @(negedge clk);
    exp_now = exp_q.pop_front();
    check($sformatf("match[%0d]", step_no), 32'(match), 32'(exp_now));
    check($sformatf("match_q_prev[%0d]", step_no), 32'(match_q), 32'(last_m));
    @(posedge clk);
    #1;
    last_m = exp_now;
`ifdef SEQ_DET_CNT_EN
    if (exp_now && exp_cnt < CNT_MAX) exp_cnt++;
`endif
    check($sformatf("match_q[%0d]", step_no), 32'(match_q), 32'(last_m));
    check($sformatf("match_cnt[%0d]", step_no), 32'(match_cnt), 32'(exp_cnt));
    step_no++;
  endtask

  // Sends n bits, first bit = bits[n-1]; exp uses the same ordering.
  task automatic stream(input int n, input logic [15:0] bits, input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, bits[i], exp[i]);
    end
  endtask

  task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    pat_in  = p;
    len_in  = l;
    overlap = ov;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("fill_after_load", 32'(fill), 32'd0);
  endtask

  // Reset is held with a live matching-looking input to prove it is discarded.
  task automatic do_reset();
    rst_n    = 1'b0;
    load     = 1'b0;
    in_valid = 1'b1;
    din      = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    last_m   = 1'b0;
    exp_cnt  = 0;
    #1;
    check("reset_fill", 32'(fill), 32'd0);
    check("reset_match_q", 32'(match_q), 32'd0);
    check("reset_match_cnt", 32'(match_cnt), 32'd0);
    check("reset_match", 32'(match), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    pat_in   = '0;
    len_in   = '0;
    overlap  = 1'b1;
    in_valid = 1'b0;
    din      = 1'b0;
    do_reset();

    // Reset pattern is 0 with length 1: a valid 0 matches, a valid 1 does not.
    stream(2, 16'b10, 16'b01);

    // Pattern 1011, overlapping.
    do_load(8'b1011, 4'd4, 1'b1);
    stream(7, 16'b1011011, 16'b0001001);

    // Non-overlapping: only three fresh bits follow the first match, too few for length 4.
    do_load(8'b1011, 4'd4, 1'b0);
    stream(7, 16'b1011011, 16'b0001000);
    check("fill_after_nonoverlap", 32'(fill), 32'd3);

    do_load(8'b11, 4'd2, 1'b0);
    stream(4, 16'b1111, 16'b0101);
    do_load(8'b11, 4'd2, 1'b1);
    stream(4, 16'b1111, 16'b0111);

    // Gaps: bits with in_valid low are ignored.
    do_load(8'b101, 4'd3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("fill_after_gap", 32'(fill), 32'd1);
    stream(2, 16'b01, 16'b01);

    // Load mid-stream suppresses what would otherwise be a match.
    do_load(8'b1011, 4'd4, 1'b1);
    stream(3, 16'b101, 16'b000);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("fill_after_midload", 32'(fill), 32'd0);
    stream(4, 16'b1011, 16'b0001);

    // Length 0 is captured as 1; length 15 is clamped to 8.
    do_load(8'b1, 4'd0, 1'b1);
    stream(4, 16'b1011, 16'b1011);
    check("fill_len0", 32'(fill), 32'd1);
    do_load(8'b10110011, 4'd15, 1'b1);
    stream(8, 16'b10110011, 16'b00000001);
    check("fill_len15", 32'(fill), 32'd8);

    // Counter saturation, then reset mid-pattern.
    do_load(8'b1, 4'd1, 1'b1);
    stream(5, 16'b11111, 16'b11111);
    do_load(8'b1011, 4'd4, 1'b1);
    stream(3, 16'b101, 16'b000);
    do_reset();
    do_load(8'b1011, 4'd4, 1'b1);
    stream(4, 16'b1011, 16'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
